rv64if_top: RTL and testbench
=============================

// Module: rv64if_top
// PURPOSE
//  Single-cycle RV64I core with a minimal F-register subset. Sits between
//  a combinational instruction memory and a combinational data memory.
//  Every instruction is fetched, executed and retired in one in_Clk cycle.
//  Memories are external. The core drives addresses and store data and
//  consumes the returned words.
// PARAMETERS
//  DATA_WIDTH  64  Width of the PC, the integer registers and the data bus.
//                  Only 64 is supported.
// PORTS
//  in_Clk          in   1   Clock. All state updates on the rising edge.
//  in_Rst_n        in   1   Asynchronous, active-low reset.
//  in_inst         in   32  Instruction word at out_inst_addr (combinational).
//  in_DM_data      in   64  Doubleword read from memory at out_addr (combinational).
//  out_inst_addr   out  64  Current PC.
//  out_addr        out  64  Data byte address, rs1+imm, for loads and stores. 0 otherwise.
//  out_wr_data     out  64  Store data. 0 when no store is executing.
//  out_DM_wr_en    out  1   High for the cycle a store executes.
// BEHAVIOUR
//  - Reset (in_Rst_n=0, takes effect immediately regardless of in_Clk):
//    PC=0, x1..x31=0, f0..f31=0, out_DM_wr_en=0, out_wr_data=0.
//  - Reset asserted mid-instruction aborts that instruction; nothing commits.
//  - First fetch after reset release is from address 0.
//  - Per cycle, all combinational: decode in_inst, read regs, compute,
//    drive the memory outputs.
//  - On the rising edge: write rd (or frd) and update the PC.
//  - Next PC = PC+4, except:
//    taken branch      -> PC+imm_b
//    JAL               -> PC+imm_j
//    JALR              -> (rs1+imm_i) & ~1
//  - x0 always reads 0; writes to x0 are discarded. f0 is a normal register.
//  - Integer ops:
//    LUI, AUIPC, JAL, JALR (rd=PC+4)
//    BEQ/BNE/BLT/BGE/BLTU/BGEU
//    ADDI/SLTI/SLTIU/XORI/ORI/ANDI; SLLI/SRLI/SRAI with 6-bit shamt
//    ADD/SUB/SLL/SLT/SLTU/XOR/SRL/SRA/OR/AND; shift amount = rs2[5:0]
//    ADDIW/SLLIW/SRLIW/SRAIW, ADDW/SUBW/SLLW/SRLW/SRAW: 32-bit result,
//    sign-extended to 64; W shift amount = 5 bits.
//  - All arithmetic wraps modulo 2^64, or 2^32 for W ops. No overflow traps.
//  - Memory: the data port is doubleword-wide, no byte enables.
//    LD  rd  = in_DM_data
//    LW  rd  = sext(in_DM_data[31:0])
//    SD  out_wr_data = rs2
//    FLW frd = {32'hFFFFFFFF, in_DM_data[31:0]} (NaN-boxed)
//    FSW out_wr_data = {32'h0, frs2[31:0]}
//  - Stores: out_DM_wr_en=1 for exactly that cycle. out_addr and
//    out_wr_data are stable all cycle. Loads never assert out_DM_wr_en.
//  - Float-register ops:
//    FMV.X.W  rd  = sext(frs1[31:0])
//    FMV.W.X  frd = {32'hFFFFFFFF, rs1[31:0]}
//    FSGNJ.S / FSGNJN.S / FSGNJX.S on bits [31:0], result NaN-boxed.
//  - Unsupported or illegal encodings (incl. FENCE/ECALL/CSR): execute as
//    NOP. No register or memory write; PC+4.
//  - Misaligned addresses are passed through unchanged. No exceptions.
// TESTING
//  - Reset: in_Rst_n=0 -> out_inst_addr=0, out_DM_wr_en=0.
//    Release -> PC goes 0,4,8 on successive edges with NOPs.
//  - ADDI x1,x0,-1; SRLI x2,x1,60; ADDIW x3,x1,0
//    -> x1=FFFF_FFFF_FFFF_FFFF, x2=0xF, x3=FFFF_FFFF_FFFF_FFFF.
//  - x1=0x100, x2=0x1234_5678_9ABC_DEF0; SD x2,8(x1)
//    -> out_addr=0x108, out_wr_data=x2, out_DM_wr_en=1 for one cycle.
//    Then LD x5,8(x1) with in_DM_data=x2 -> x5=x2, out_DM_wr_en=0.
//  - BNE x0,x1,+16 at PC=0x20 with x1!=0 -> next PC=0x30.
//    JALR x1,x2,3 with x2=0x40 -> PC=0x42, x1=PC+4.
//  - FLW f1,0(x0) with in_DM_data[31:0]=0x3F80_0000; FSGNJN.S f2,f1,f1;
//    FMV.X.W x4,f2 -> x4=FFFF_FFFF_BF80_0000.
//  - Assert in_Rst_n=0 mid-cycle during SD
//    -> out_DM_wr_en drops immediately, PC=0.

Source files
------------

// File: rtl/rv64if_top.sv
// rv64if_top: single-cycle RV64I core with a small single-precision register subset.
// Each instruction is fetched, executed and retired in one cycle against combinational memories.
module rv64if_top #(
    parameter int DATA_WIDTH = 64
) (
    input  logic                  in_Clk,
    input  logic                  in_Rst_n,
    input  logic [31:0]           in_inst,
    input  logic [DATA_WIDTH-1:0] in_DM_data,
    output logic [DATA_WIDTH-1:0] out_inst_addr,
    output logic [DATA_WIDTH-1:0] out_addr,
    output logic [DATA_WIDTH-1:0] out_wr_data,
    output logic                  out_DM_wr_en
);
    localparam int XLEN = DATA_WIDTH;

    localparam logic [6:0] OPC_LUI      = 7'b0110111;
    localparam logic [6:0] OPC_AUIPC    = 7'b0010111;
    localparam logic [6:0] OPC_JAL      = 7'b1101111;
    localparam logic [6:0] OPC_JALR     = 7'b1100111;
    localparam logic [6:0] OPC_BRANCH   = 7'b1100011;
    localparam logic [6:0] OPC_LOAD     = 7'b0000011;
    localparam logic [6:0] OPC_STORE    = 7'b0100011;
    localparam logic [6:0] OPC_OP_IMM   = 7'b0010011;
    localparam logic [6:0] OPC_OP       = 7'b0110011;
    localparam logic [6:0] OPC_OP_IMM32 = 7'b0011011;
    localparam logic [6:0] OPC_OP32     = 7'b0111011;
    localparam logic [6:0] OPC_LOAD_FP  = 7'b0000111;
    localparam logic [6:0] OPC_STORE_FP = 7'b0100111;
    localparam logic [6:0] OPC_OP_FP    = 7'b1010011;

    logic [XLEN-1:0] r_pc;
    logic [XLEN-1:0] r_x [32];
    // Only the low word of each f register is kept: every write NaN-boxes the
    // upper half with ones and nothing ever reads it back.
    logic [31:0]     r_f [32];

    logic [6:0]      w_opc;
    logic [4:0]      w_rd, w_rs1, w_rs2;
    logic [2:0]      w_f3;
    logic [6:0]      w_f7;
    logic [XLEN-1:0] w_imm_i, w_imm_s, w_imm_b, w_imm_u, w_imm_j;
    logic [XLEN-1:0] w_rs1_val, w_rs2_val;
    logic [31:0]     w_frs1, w_frs2;
    logic            w_br_taken;

    logic [XLEN-1:0] w_next_pc;
    logic            w_x_we;
    logic [XLEN-1:0] w_x_wd;
    logic            w_f_we;
    logic [31:0]     w_f_wd;
    logic [XLEN-1:0] w_mem_addr;
    logic [XLEN-1:0] w_st_data;
    logic            w_st_en;
    logic [31:0]     w_w32;

    assign w_opc = in_inst[6:0];
    assign w_rd  = in_inst[11:7];
    assign w_f3  = in_inst[14:12];
    assign w_rs1 = in_inst[19:15];
    assign w_rs2 = in_inst[24:20];
    assign w_f7  = in_inst[31:25];

    assign w_imm_i = {{52{in_inst[31]}}, in_inst[31:20]};
    assign w_imm_s = {{52{in_inst[31]}}, in_inst[31:25], in_inst[11:7]};
    assign w_imm_b = {{51{in_inst[31]}}, in_inst[31], in_inst[7], in_inst[30:25], in_inst[11:8], 1'b0};
    assign w_imm_u = {{32{in_inst[31]}}, in_inst[31:12], 12'b0};
    assign w_imm_j = {{43{in_inst[31]}}, in_inst[31], in_inst[19:12], in_inst[20], in_inst[30:21], 1'b0};

    assign w_rs1_val = (w_rs1 == 5'd0) ? '0 : r_x[w_rs1];
    assign w_rs2_val = (w_rs2 == 5'd0) ? '0 : r_x[w_rs2];
    assign w_frs1    = r_f[w_rs1];
    assign w_frs2    = r_f[w_rs2];

    always_comb begin
        w_br_taken = 1'b0;
        case (w_f3)
            3'b000:  w_br_taken = (w_rs1_val == w_rs2_val);
            3'b001:  w_br_taken = (w_rs1_val != w_rs2_val);
            3'b100:  w_br_taken = ($signed(w_rs1_val) <  $signed(w_rs2_val));
            3'b101:  w_br_taken = ($signed(w_rs1_val) >= $signed(w_rs2_val));
            3'b110:  w_br_taken = (w_rs1_val <  w_rs2_val);
            3'b111:  w_br_taken = (w_rs1_val >= w_rs2_val);
            default: w_br_taken = 1'b0;
        endcase
    end

    always_comb begin
        w_next_pc  = r_pc + 64'd4;
        w_x_we     = 1'b0;
        w_x_wd     = '0;
        w_f_we     = 1'b0;
        w_f_wd     = '0;
        w_mem_addr = '0;
        w_st_data  = '0;
        w_st_en    = 1'b0;
        w_w32      = '0;
        case (w_opc)
            OPC_LUI: begin
                w_x_we = 1'b1;
                w_x_wd = w_imm_u;
            end
            OPC_AUIPC: begin
                w_x_we = 1'b1;
                w_x_wd = r_pc + w_imm_u;
            end
            OPC_JAL: begin
                w_x_we    = 1'b1;
                w_x_wd    = r_pc + 64'd4;
                w_next_pc = r_pc + w_imm_j;
            end
            OPC_JALR: if (w_f3 == 3'b000) begin
                w_x_we    = 1'b1;
                w_x_wd    = r_pc + 64'd4;
                w_next_pc = (w_rs1_val + w_imm_i) & ~64'd1;
            end
            OPC_BRANCH: if (w_br_taken) w_next_pc = r_pc + w_imm_b;
            OPC_LOAD: if (w_f3 == 3'b011 || w_f3 == 3'b010) begin
                w_mem_addr = w_rs1_val + w_imm_i;
                w_x_we     = 1'b1;
                w_x_wd     = (w_f3 == 3'b011) ? in_DM_data
                                              : {{32{in_DM_data[31]}}, in_DM_data[31:0]};
            end
            OPC_STORE: if (w_f3 == 3'b011) begin
                w_mem_addr = w_rs1_val + w_imm_s;
                w_st_data  = w_rs2_val;
                w_st_en    = 1'b1;
            end
            OPC_LOAD_FP: if (w_f3 == 3'b010) begin
                w_mem_addr = w_rs1_val + w_imm_i;
                w_f_we     = 1'b1;
                w_f_wd     = in_DM_data[31:0];
            end
            OPC_STORE_FP: if (w_f3 == 3'b010) begin
                w_mem_addr = w_rs1_val + w_imm_s;
                w_st_data  = {32'h0, w_frs2};
                w_st_en    = 1'b1;
            end
            OPC_OP_IMM: begin
                w_x_we = 1'b1;
                case (w_f3)
                    3'b000: w_x_wd = w_rs1_val + w_imm_i;
                    3'b010: w_x_wd = {63'b0, ($signed(w_rs1_val) < $signed(w_imm_i))};
                    3'b011: w_x_wd = {63'b0, (w_rs1_val < w_imm_i)};
                    3'b100: w_x_wd = w_rs1_val ^ w_imm_i;
                    3'b110: w_x_wd = w_rs1_val | w_imm_i;
                    3'b111: w_x_wd = w_rs1_val & w_imm_i;
                    3'b001: begin
                        if (in_inst[31:26] == 6'b000000) w_x_wd = w_rs1_val << in_inst[25:20];
                        else w_x_we = 1'b0;
                    end
                    default: begin
                        if (in_inst[31:26] == 6'b000000)      w_x_wd = w_rs1_val >> in_inst[25:20];
                        else if (in_inst[31:26] == 6'b010000) w_x_wd = $signed(w_rs1_val) >>> in_inst[25:20];
                        else w_x_we = 1'b0;
                    end
                endcase
            end
            OPC_OP: begin
                w_x_we = 1'b1;
                if (w_f7 == 7'b0000000) begin
                    case (w_f3)
                        3'b000:  w_x_wd = w_rs1_val + w_rs2_val;
                        3'b001:  w_x_wd = w_rs1_val << w_rs2_val[5:0];
                        3'b010:  w_x_wd = {63'b0, ($signed(w_rs1_val) < $signed(w_rs2_val))};
                        3'b011:  w_x_wd = {63'b0, (w_rs1_val < w_rs2_val)};
                        3'b100:  w_x_wd = w_rs1_val ^ w_rs2_val;
                        3'b101:  w_x_wd = w_rs1_val >> w_rs2_val[5:0];
                        3'b110:  w_x_wd = w_rs1_val | w_rs2_val;
                        default: w_x_wd = w_rs1_val & w_rs2_val;
                    endcase
                end else if (w_f7 == 7'b0100000 && w_f3 == 3'b000) w_x_wd = w_rs1_val - w_rs2_val;
                else if (w_f7 == 7'b0100000 && w_f3 == 3'b101) w_x_wd = $signed(w_rs1_val) >>> w_rs2_val[5:0];
                else w_x_we = 1'b0;
            end
            OPC_OP_IMM32: begin
                w_x_we = 1'b1;
                if (w_f3 == 3'b000)                           w_w32 = w_rs1_val[31:0] + w_imm_i[31:0];
                else if (w_f3 == 3'b001 && w_f7 == 7'b0000000) w_w32 = w_rs1_val[31:0] << w_rs2;
                else if (w_f3 == 3'b101 && w_f7 == 7'b0000000) w_w32 = w_rs1_val[31:0] >> w_rs2;
                else if (w_f3 == 3'b101 && w_f7 == 7'b0100000) w_w32 = $signed(w_rs1_val[31:0]) >>> w_rs2;
                else w_x_we = 1'b0;
                w_x_wd = {{32{w_w32[31]}}, w_w32};
            end
            OPC_OP32: begin
                w_x_we = 1'b1;
                if (w_f3 == 3'b000 && w_f7 == 7'b0000000)      w_w32 = w_rs1_val[31:0] + w_rs2_val[31:0];
                else if (w_f3 == 3'b000 && w_f7 == 7'b0100000) w_w32 = w_rs1_val[31:0] - w_rs2_val[31:0];
                else if (w_f3 == 3'b001 && w_f7 == 7'b0000000) w_w32 = w_rs1_val[31:0] << w_rs2_val[4:0];
                else if (w_f3 == 3'b101 && w_f7 == 7'b0000000) w_w32 = w_rs1_val[31:0] >> w_rs2_val[4:0];
                else if (w_f3 == 3'b101 && w_f7 == 7'b0100000) w_w32 = $signed(w_rs1_val[31:0]) >>> w_rs2_val[4:0];
                else w_x_we = 1'b0;
                w_x_wd = {{32{w_w32[31]}}, w_w32};
            end
            OPC_OP_FP: begin
                if (w_f7 == 7'b0010000 && w_f3 != 3'b011 && w_f3[2] == 1'b0) begin
                    w_f_we = 1'b1;
                    case (w_f3)
                        3'b000:  w_f_wd = {w_frs2[31], w_frs1[30:0]};
                        3'b001:  w_f_wd = {~w_frs2[31], w_frs1[30:0]};
                        default: w_f_wd = {w_frs1[31] ^ w_frs2[31], w_frs1[30:0]};
                    endcase
                end else if (w_f7 == 7'b1110000 && w_rs2 == 5'd0 && w_f3 == 3'b000) begin
                    w_x_we = 1'b1;
                    w_x_wd = {{32{w_frs1[31]}}, w_frs1};
                end else if (w_f7 == 7'b1111000 && w_rs2 == 5'd0 && w_f3 == 3'b000) begin
                    w_f_we = 1'b1;
                    w_f_wd = w_rs1_val[31:0];
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge in_Clk or negedge in_Rst_n) begin
        if (!in_Rst_n) begin
            r_pc <= '0;
            for (int i = 0; i < 32; i++) begin
                r_x[i] <= '0;
                r_f[i] <= '0;
            end
        end else begin
            r_pc <= w_next_pc;
            if (w_x_we && w_rd != 5'd0) r_x[w_rd] <= w_x_wd;
            if (w_f_we) r_f[w_rd] <= w_f_wd;
        end
    end

    // Memory outputs are gated by reset so an in-flight store is dropped at once.
    assign out_inst_addr = r_pc;
    assign out_addr      = in_Rst_n ? w_mem_addr : '0;
    assign out_wr_data   = in_Rst_n ? w_st_data  : '0;
    assign out_DM_wr_en  = in_Rst_n & w_st_en;

endmodule

// File: tb/tb_rv64if_top.sv
// Directed bench for rv64if_top: hand-encoded instructions, register values observed
// through SD/FSW stores, expected values computed by hand.
module tb_rv64if_top;
    logic        in_Clk;
    logic        in_Rst_n;
    logic [31:0] in_inst;
    logic [63:0] in_DM_data;
    logic [63:0] out_inst_addr;
    logic [63:0] out_addr;
    logic [63:0] out_wr_data;
    logic        out_DM_wr_en;

    rv64if_top #(.DATA_WIDTH(64)) dut (
        .in_Clk        (in_Clk),
        .in_Rst_n      (in_Rst_n),
        .in_inst       (in_inst),
        .in_DM_data    (in_DM_data),
        .out_inst_addr (out_inst_addr),
        .out_addr      (out_addr),
        .out_wr_data   (out_wr_data),
        .out_DM_wr_en  (out_DM_wr_en)
    );

    localparam logic [6:0] OP_IMM  = 7'b0010011;
    localparam logic [6:0] OP_RR   = 7'b0110011;
    localparam logic [6:0] OP_IMMW = 7'b0011011;
    localparam logic [6:0] OP_RRW  = 7'b0111011;
    localparam logic [6:0] OP_LD   = 7'b0000011;
    localparam logic [6:0] OP_ST   = 7'b0100011;
    localparam logic [6:0] OP_FLD  = 7'b0000111;
    localparam logic [6:0] OP_FST  = 7'b0100111;
    localparam logic [6:0] OP_FP   = 7'b1010011;
    localparam logic [6:0] OP_LUI  = 7'b0110111;
    localparam logic [6:0] OP_JALR = 7'b1100111;
    localparam logic [31:0] NOP    = 32'h0000_0013;
    localparam logic [63:0] VAL    = 64'h1234_5678_9ABC_DEF0;

    int          n_cmp;
    int          n_bad;
    logic [63:0] pc_e;
    logic [63:0] tpc;

    // clock / reset
    initial in_Clk = 1'b0;
    always #5 in_Clk = ~in_Clk;

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1);
    end

    function automatic logic [31:0] i_t(input logic [11:0] imm, input logic [4:0] rs1,
                                        input logic [2:0] f3, input logic [4:0] rd, input logic [6:0] op);
        return {imm, rs1, f3, rd, op};
    endfunction

    function automatic logic [31:0] r_t(input logic [6:0] f7, input logic [4:0] rs2, input logic [4:0] rs1,
                                        input logic [2:0] f3, input logic [4:0] rd, input logic [6:0] op);
        return {f7, rs2, rs1, f3, rd, op};
    endfunction

    function automatic logic [31:0] s_t(input logic [11:0] imm, input logic [4:0] rs2, input logic [4:0] rs1,
                                        input logic [2:0] f3, input logic [6:0] op);
        return {imm[11:5], rs2, rs1, f3, imm[4:0], op};
    endfunction

    function automatic logic [31:0] b_t(input logic [12:0] imm, input logic [4:0] rs2, input logic [4:0] rs1,
                                        input logic [2:0] f3);
        return {imm[12], imm[10:5], rs2, rs1, f3, imm[4:1], imm[11], 7'b1100011};
    endfunction

    function automatic logic [31:0] j_t(input logic [20:0] imm, input logic [4:0] rd);
        return {imm[20], imm[10:1], imm[11], imm[19:12], rd, 7'b1101111};
    endfunction

    function automatic logic [31:0] sd_t(input logic [4:0] rs2, input logic [4:0] rs1, input logic [11:0] imm);
        return s_t(imm, rs2, rs1, 3'b011, OP_ST);
    endfunction

    // scoreboard check
    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // driver: present one instruction for a whole cycle, check the PC it sits at
    task automatic exec(input string tag, input logic [31:0] inst, input logic [63:0] dm);
        @(negedge in_Clk);
        in_inst    = inst;
        in_DM_data = dm;
        #1;
        check({tag, ".pc"}, out_inst_addr, pc_e);
        pc_e = pc_e + 64'd4;
    endtask

    task automatic obs(input string tag, input logic [4:0] xr, input logic [63:0] exp);
        exec(tag, sd_t(xr, 5'd0, 12'd0), 64'd0);
        check(tag, out_wr_data, exp);
    endtask

    initial begin
        n_cmp      = 0;
        n_bad      = 0;
        pc_e       = 64'd0;
        in_Rst_n   = 1'b0;
        in_inst    = sd_t(5'd2, 5'd1, 12'd8);
        in_DM_data = 64'd0;
        #3;
        check("rst.pc", out_inst_addr, 64'd0);
        check("rst.wr_en", {63'd0, out_DM_wr_en}, 64'd0);
        check("rst.wr_data", out_wr_data, 64'd0);

        @(negedge in_Clk);
        in_inst  = NOP;
        in_Rst_n = 1'b1;
        #1;
        check("rel.pc0", out_inst_addr, 64'd0);
        pc_e = 64'd4;
        exec("rel.nop4", NOP, 64'd0);
        exec("rel.nop8", NOP, 64'd0);

        exec("addi_m1", i_t(12'hFFF, 5'd0, 3'b000, 5'd1, OP_IMM), 64'd0);
        exec("srli60", i_t(12'h03C, 5'd1, 3'b101, 5'd2, OP_IMM), 64'd0);
        exec("addiw", i_t(12'h000, 5'd1, 3'b000, 5'd3, OP_IMMW), 64'd0);
        obs("x1_all1", 5'd1, 64'hFFFF_FFFF_FFFF_FFFF);
        check("sd.wr_en", {63'd0, out_DM_wr_en}, 64'd1);
        obs("x2_srli", 5'd2, 64'h0000_0000_0000_000F);
        obs("x3_addiw", 5'd3, 64'hFFFF_FFFF_FFFF_FFFF);

        tpc = pc_e;
        exec("bne_tk", b_t(13'd16, 5'd1, 5'd0, 3'b001), 64'd0);
        pc_e = tpc + 64'd16;
        exec("beq_nt", b_t(13'd16, 5'd1, 5'd0, 3'b000), 64'd0);

        exec("addi_100", i_t(12'h100, 5'd0, 3'b000, 5'd1, OP_IMM), 64'd0);
        exec("ld_val", i_t(12'h000, 5'd0, 3'b011, 5'd2, OP_LD), VAL);
        check("ld.wr_en", {63'd0, out_DM_wr_en}, 64'd0);
        exec("sd_108", sd_t(5'd2, 5'd1, 12'd8), 64'd0);
        check("sd108.addr", out_addr, 64'h108);
        check("sd108.data", out_wr_data, VAL);
        check("sd108.wr_en", {63'd0, out_DM_wr_en}, 64'd1);
        exec("ld_108", i_t(12'h008, 5'd1, 3'b011, 5'd5, OP_LD), VAL);
        check("ld108.addr", out_addr, 64'h108);
        check("ld108.wr_en", {63'd0, out_DM_wr_en}, 64'd0);
        obs("x5_ld", 5'd5, VAL);

        exec("lw_neg", i_t(12'h000, 5'd0, 3'b010, 5'd6, OP_LD), 64'h5555_5555_8000_0001);
        obs("x6_lw", 5'd6, 64'hFFFF_FFFF_8000_0001);
        exec("sub", r_t(7'b0100000, 5'd2, 5'd0, 3'b000, 5'd7, OP_RR), 64'd0);
        obs("x7_sub", 5'd7, 64'hEDCB_A987_6543_2110);
        exec("srl48", r_t(7'b0000000, 5'd2, 5'd6, 3'b101, 5'd8, OP_RR), 64'd0);
        obs("x8_srl", 5'd8, 64'h0000_0000_0000_FFFF);
        exec("sraiw4", i_t(12'h404, 5'd6, 3'b101, 5'd9, OP_IMMW), 64'd0);
        obs("x9_sraiw", 5'd9, 64'hFFFF_FFFF_F800_0000);
        exec("addw_wrap", r_t(7'b0000000, 5'd6, 5'd6, 3'b000, 5'd10, OP_RRW), 64'd0);
        obs("x10_addw", 5'd10, 64'd2);
        exec("slt", r_t(7'b0000000, 5'd0, 5'd6, 3'b010, 5'd11, OP_RR), 64'd0);
        obs("x11_slt", 5'd11, 64'd1);
        exec("sltu", r_t(7'b0000000, 5'd0, 5'd6, 3'b011, 5'd12, OP_RR), 64'd0);
        obs("x12_sltu", 5'd12, 64'd0);
        exec("lui", {20'h80000, 5'd14, OP_LUI}, 64'd0);
        obs("x14_lui", 5'd14, 64'hFFFF_FFFF_8000_0000);

        exec("addi_40", i_t(12'h040, 5'd0, 3'b000, 5'd2, OP_IMM), 64'd0);
        tpc = pc_e;
        exec("jalr", i_t(12'h003, 5'd2, 3'b000, 5'd1, OP_JALR), 64'd0);
        pc_e = 64'h42;
        obs("x1_jalr", 5'd1, tpc + 64'd4);
        tpc = pc_e;
        exec("jal", j_t(21'd8, 5'd13), 64'd0);
        pc_e = tpc + 64'd8;
        obs("x13_jal", 5'd13, tpc + 64'd4);

        exec("flw", i_t(12'h000, 5'd0, 3'b010, 5'd1, OP_FLD), 64'hABCD_EF01_3F80_0000);
        exec("fsgnjn", r_t(7'b0010000, 5'd1, 5'd1, 3'b001, 5'd2, OP_FP), 64'd0);
        exec("fmv_x_w", r_t(7'b1110000, 5'd0, 5'd2, 3'b000, 5'd4, OP_FP), 64'd0);
        obs("x4_fmvxw", 5'd4, 64'hFFFF_FFFF_BF80_0000);
        exec("fsw_f2", s_t(12'd16, 5'd2, 5'd0, 3'b010, OP_FST), 64'd0);
        check("fsw.addr", out_addr, 64'd16);
        check("fsw.data", out_wr_data, 64'h0000_0000_BF80_0000);
        check("fsw.wr_en", {63'd0, out_DM_wr_en}, 64'd1);
        exec("fmv_w_x", r_t(7'b1111000, 5'd0, 5'd6, 3'b000, 5'd3, OP_FP), 64'd0);
        exec("fsw_f3", s_t(12'd0, 5'd3, 5'd0, 3'b010, OP_FST), 64'd0);
        check("fsw3.data", out_wr_data, 64'h0000_0000_8000_0001);

        exec("addi_x0", i_t(12'h005, 5'd0, 3'b000, 5'd0, OP_IMM), 64'd0);
        obs("x0_zero", 5'd0, 64'd0);
        exec("ecall", 32'h0000_0073, 64'd0);
        check("ecall.wr_en", {63'd0, out_DM_wr_en}, 64'd0);
        exec("sb_unsup", s_t(12'd0, 5'd2, 5'd0, 3'b000, OP_ST), 64'd0);
        check("sb.wr_en", {63'd0, out_DM_wr_en}, 64'd0);
        obs("x2_after_nops", 5'd2, 64'h40);

        exec("sd_abort", sd_t(5'd2, 5'd0, 12'd8), 64'd0);
        check("abort.pre_wr_en", {63'd0, out_DM_wr_en}, 64'd1);
        #2;
        in_Rst_n = 1'b0;
        #1;
        check("abort.wr_en", {63'd0, out_DM_wr_en}, 64'd0);
        check("abort.wr_data", out_wr_data, 64'd0);
        check("abort.pc", out_inst_addr, 64'd0);
        @(negedge in_Clk);
        in_inst  = sd_t(5'd2, 5'd0, 12'd0);
        in_Rst_n = 1'b1;
        #1;
        check("post.pc", out_inst_addr, 64'd0);
        check("post.x2", out_wr_data, 64'd0);
        check("post.wr_en", {63'd0, out_DM_wr_en}, 64'd1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
